add_sub_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single registered 4-bit add/sub unit (add_sub) among NUM_REQ requesters. It accepts one operation at a time over a valid/ready handshake and drives the unit's num1/num2/op inputs. It tracks the unit's one-cycle register latency, captures res, and returns it with the requester ID over a valid/ready response channel. It sits between the requesting pipeline stages and the add_sub instance, which is instantiated beside it.

---
 rtl/add_sub_arbiter_if.sv | 30 +++
 rtl/add_sub_arbiter.sv | 135 +++++++++++++
 tb/tb_add_sub_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/add_sub_arbiter_if.sv
// Requester, add_sub unit and response signals shared between the arbiter
// (slave side) and its environment (master side).
interface add_sub_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [4*NUM_REQ-1:0] req_num1;
  logic [4*NUM_REQ-1:0] req_num2;
  logic [NUM_REQ-1:0]   req_op;
  logic [3:0]           au_num1;
  logic [3:0]           au_num2;
  logic                 au_op;
  logic [4:0]           au_res;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [4:0]           rsp_res;
  logic [ID_W-1:0]      rsp_id;

  modport master (
    output req_valid, req_num1, req_num2, req_op, rsp_ready, au_res,
    input  req_ready, au_num1, au_num2, au_op, rsp_valid, rsp_res, rsp_id
  );

  modport slave (
    input  req_valid, req_num1, req_num2, req_op, rsp_ready, au_res,
    output req_ready, au_num1, au_num2, au_op, rsp_valid, rsp_res, rsp_id
  );
endinterface

// File: rtl/add_sub_arbiter.sv
// Round-robin arbiter that feeds one registered add/sub unit from NUM_REQ
// requesters and returns each result tagged with the requester index.
module add_sub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  add_sub_arbiter_if.slave  bus,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t               state_r;
  state_t               next_state_s;
  logic [ID_W-1:0]      ptr_r;
  logic [ID_W-1:0]      gnt_id_s;
  logic                 gnt_found_s;
  logic                 grant_s;
  logic [NUM_REQ-1:0]   req_ready_s;
  logic [3:0]           au_num1_r;
  logic [3:0]           au_num2_r;
  logic                 au_op_r;
  logic                 rsp_valid_r;
  logic [4:0]           rsp_res_r;
  logic [ID_W-1:0]      rsp_id_r;

  // Rotating-priority search: first valid requester after the last winner.
  always_comb begin : grant_search
    int              idx;
    logic [ID_W-1:0] cand;
    gnt_found_s = 1'b0;
    gnt_id_s    = '0;
    idx         = 0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr_r) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      cand = idx[ID_W-1:0];
      if (!gnt_found_s && bus.req_valid[cand]) begin
        gnt_found_s = 1'b1;
        gnt_id_s    = cand;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  assign grant_s = (state_r == IDLE) && gnt_found_s;

  // One-hot accept towards the winning requester, forced low during reset.
  always_comb begin
    req_ready_s = '0;
    if (!rst && grant_s) begin
      req_ready_s[gnt_id_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Sequencing: grant, wait for the unit's register, capture, hand off.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          next_state_s = EXEC;
        end else begin
          next_state_s = IDLE;
        end
      end
      EXEC: next_state_s = CAPT;
      CAPT: next_state_s = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Operand, pointer and response registers; au_res is only sampled in CAPT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r       <= ID_W'(NUM_REQ - 1);
      au_num1_r   <= 4'd0;
      au_num2_r   <= 4'd0;
      au_op_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_res_r   <= 5'd0;
      rsp_id_r    <= '0;
    end else begin
      if (grant_s) begin
        au_num1_r <= bus.req_num1[{gnt_id_s, 2'b00} +: 4];
        au_num2_r <= bus.req_num2[{gnt_id_s, 2'b00} +: 4];
        au_op_r   <= bus.req_op[gnt_id_s];
        rsp_id_r  <= gnt_id_s;
        ptr_r     <= gnt_id_s;
      end
      if (state_r == CAPT) begin
        rsp_res_r   <= bus.au_res;
        rsp_valid_r <= 1'b1;
      end else if (state_r == RESP && bus.rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.au_num1   = au_num1_r;
  assign bus.au_num2   = au_num2_r;
  assign bus.au_op     = au_op_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_res   = rsp_res_r;
  assign bus.rsp_id    = rsp_id_r;
  assign busy          = (state_r != IDLE);

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Directed and randomized bench for add_sub_arbiter with a behavioural
// add_sub unit and a round-robin/arithmetic reference model.
module tb_add_sub_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic clk;
  logic rst;
  logic busy;

  int checks;
  int errors;
  int ptr_m;
  int a_m  [NUM_REQ];
  int b_m  [NUM_REQ];
  int op_m [NUM_REQ];
  int last_a;
  int last_b;
  int last_op;
  logic [NUM_REQ-1:0] vmask;

  add_sub_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  add_sub_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  // Registered add/sub unit sitting beside the arbiter.
  always_ff @(posedge clk) begin
    bus.au_res <= bus.au_op ? 5'({1'b0, bus.au_num1} + {1'b0, bus.au_num2})
                            : 5'({1'b0, bus.au_num1} - {1'b0, bus.au_num2});
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Winner = first valid requester met when walking the ring past the last winner.
  function automatic int predict(input logic [NUM_REQ-1:0] m);
    int w;
    w = -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (w < 0 && m[(ptr_m + k) % NUM_REQ]) w = (ptr_m + k) % NUM_REQ;
    end
    return w;
  endfunction

  function automatic int ref_res(input int a, input int b, input int op);
    return op != 0 ? (a + b) % 32 : (a - b + 32) % 32;
  endfunction

  task automatic set_req(input int i, input int a, input int b, input int op);
    a_m[i] = a; b_m[i] = b; op_m[i] = op;
    bus.req_num1[4*i +: 4] = 4'(a);
    bus.req_num2[4*i +: 4] = 4'(b);
    bus.req_op[i]          = (op != 0);
    vmask[i]               = 1'b1;
    bus.req_valid          = vmask;
  endtask

  task automatic clear_req(input int i);
    vmask[i]      = 1'b0;
    bus.req_valid = vmask;
  endtask

  // Called at a negedge in IDLE with requests set up; returns at a negedge in IDLE.
  task automatic do_op(input int bp, input bit keep);
    int g;
    int expv;
    #1;
    g = predict(vmask);
    checks++;
    assert (g >= 0) else begin
      errors++;
      $error("FAIL no_request observed=%0d expected=%0d", g, 0);
    end
    if (g >= 0) begin
      chk("grant_ready", 32'(bus.req_ready), 32'(1) << g);
      chk("idle_busy", 32'(busy), 32'd0);
      expv = ref_res(a_m[g], b_m[g], op_m[g]);
      @(negedge clk);
      ptr_m = g; last_a = a_m[g]; last_b = b_m[g]; last_op = op_m[g];
      chk("exec_num1", 32'(bus.au_num1), 32'(last_a));
      chk("exec_num2", 32'(bus.au_num2), 32'(last_b));
      chk("exec_op", 32'(bus.au_op), 32'(last_op));
      chk("exec_ready", 32'(bus.req_ready), 32'd0);
      chk("exec_busy", 32'(busy), 32'd1);
      if (keep) set_req(g, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
      else clear_req(g);
      @(negedge clk);
      chk("capt_valid", 32'(bus.rsp_valid), 32'd0);
      chk("capt_ready", 32'(bus.req_ready), 32'd0);
      bus.rsp_ready = (bp == 0);
      @(negedge clk);
      chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_res", 32'(bus.rsp_res), 32'(expv));
      chk("rsp_id", 32'(bus.rsp_id), 32'(g));
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
        chk("hold_res", 32'(bus.rsp_res), 32'(expv));
        chk("hold_id", 32'(bus.rsp_id), 32'(g));
        chk("hold_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("done_valid", 32'(bus.rsp_valid), 32'd0);
      chk("done_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    checks = 0; errors = 0; ptr_m = NUM_REQ - 1;
    last_a = 0; last_b = 0; last_op = 0;
    vmask = '0;
    bus.req_valid = '0; bus.req_num1 = '0; bus.req_num2 = '0; bus.req_op = '0;
    bus.rsp_ready = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    bus.req_valid = 4'b1111;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_num1", 32'(bus.au_num1), 32'd0);
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_res", 32'(bus.rsp_res), 32'd0);
    chk("rst_id", 32'(bus.rsp_id), 32'd0);
    bus.req_valid = vmask;
    rst = 1'b0;
    @(negedge clk);

    // Single add and the subtract corner cases.
    set_req(0, 11, 4, 1);  do_op(0, 1'b0);
    set_req(2, 3, 5, 0);   do_op(0, 1'b0);
    set_req(2, 5, 3, 0);   do_op(0, 1'b0);
    set_req(1, 0, 15, 0);  do_op(0, 1'b0);
    set_req(3, 15, 15, 1); do_op(0, 1'b0);

    // Backpressure with a competing requester waiting.
    set_req(0, 9, 8, 1);
    set_req(2, 1, 2, 1);
    do_op(5, 1'b0);
    do_op(0, 1'b0);

    // Withdrawn request: no grant, no state change.
    set_req(1, 9, 9, 1);
    #2;
    chk("withdraw_ready", 32'(bus.req_ready), 32'd2);
    clear_req(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("withdraw_busy", 32'(busy), 32'd0);
      chk("withdraw_num1", 32'(bus.au_num1), 32'(last_a));
      chk("withdraw_num2", 32'(bus.au_num2), 32'(last_b));
      chk("withdraw_op", 32'(bus.au_op), 32'(last_op));
    end

    // Reset while the operation sits in CAPT.
    set_req(3, 12, 9, 0);
    @(negedge clk);
    clear_req(3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_num1", 32'(bus.au_num1), 32'd0);
    chk("midrst_num2", 32'(bus.au_num2), 32'd0);
    chk("midrst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_res", 32'(bus.rsp_res), 32'd0);
    chk("midrst_id", 32'(bus.rsp_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ptr_m = NUM_REQ - 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("postrst_busy", 32'(busy), 32'd0);
    end
    set_req(1, 6, 7, 1);
    set_req(3, 2, 9, 0);
    do_op(0, 1'b0);
    do_op(0, 1'b0);

    // All requesters asserting continuously.
    for (int i = 0; i < NUM_REQ; i++) begin
      set_req(i, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
    end
    for (int n = 0; n < 8; n++) do_op(0, 1'b1);

    // Random arrivals with random response backpressure.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!vmask[i] && $urandom_range(0, 1) == 1)
          set_req(i, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
      end
      if (vmask == '0)
        set_req($urandom_range(0, NUM_REQ - 1), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
      do_op($urandom_range(0, 3), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
